display_sched: RTL and testbench
================================

DISPLAY_SCHED -- requirements
Module: display_sched

Interface
REQ-001 Parameter DIV, default 2: number of clk cycles per ser_clk phase (low or high) and per latch pulse; legal range 1..255.
REQ-002 Parameter REFRESH, default 1000: number of idle clk cycles after frame_done before the last frame is re-sent.
REQ-003 clk  input  1  clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_result  input  1  level request from the result path; held until ack_result.
REQ-006 bcd_result  input  16  4 BCD digits for the result; [15:12] is the leftmost digit.
REQ-007 req_entry  input  1  level request from the operand-entry path; held until ack_entry.
REQ-008 bcd_entry  input  16  4 BCD digits for the operand entry; same digit order.
REQ-009 err_in  input  1  error level; forces an all-dash frame at grant.
REQ-010 ack_result  output  1  one-cycle pulse when req_result is granted.
REQ-011 ack_entry  output  1  one-cycle pulse when req_entry is granted.
REQ-012 ser_data  output  1  serial segment bit to the external shift register.
REQ-013 ser_clk  output  1  shift clock to the external register; data is stable on its rising edge.
REQ-014 ser_latch  output  1  storage-register latch strobe.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frame_done  output  1  one-cycle pulse after each frame is latched.

Function
REQ-017 Segment map (abcdefg,dp):
- 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6.
- Any nibble >9 maps to 02 (dash).
REQ-018 The frame is 32 bits: {seg(d3), seg(d2), seg(d1), seg(d0)}, shifted out MSB first (bit 31 first).
REQ-019 FSM states are IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, DONE.
REQ-020 IDLE grant order, evaluated every cycle in IDLE:
- req_result, then req_entry, then refresh.
- Refresh fires when the refresh counter reaches REFRESH and a frame has been sent since reset.
REQ-021 At grant, in the same cycle:
- The winning ack pulses for 1 cycle.
- The frame register loads the selected bcd mapped through REQ-017, or 32'h02020202 if err_in=1.
- The last-frame register is updated with the loaded frame.
- The FSM enters LOAD.
- A refresh grant reloads the last frame and pulses no ack.
REQ-022 LOAD lasts 1 cycle; ser_data is driven with frame bit 31; the bit counter is cleared to 0.
REQ-023 SHIFT_LO: ser_clk=0 for DIV cycles, then go to SHIFT_HI.
REQ-024 SHIFT_HI: ser_clk=1 for DIV cycles, then:
- If bit counter = 31, go to LATCH.
- Otherwise increment the counter, present the next bit on ser_data, and go to SHIFT_LO.
REQ-025 ser_data changes only on SHIFT_HI to SHIFT_LO transitions and is stable throughout each high phase.
REQ-026 LATCH: ser_latch=1, ser_clk=0 for DIV cycles, then go to DONE.
REQ-027 DONE lasts 1 cycle with frame_done=1; it clears the refresh counter and returns to IDLE.
REQ-028 Frame latency from grant edge to frame_done: 1 + 64*DIV + DIV + 1 cycles (132 at DIV=2).
REQ-029 Requests arriving while busy are not acknowledged; they are served in IDLE after frame_done, in priority order.
REQ-030 Simultaneous req_result and req_entry in IDLE: only ack_result pulses; entry is served on the next frame if still held.
REQ-031 The refresh counter increments in IDLE only and saturates at REFRESH; a request arriving at the same cycle as refresh wins.
REQ-032 err_in is sampled only at grant; changes during a frame do not alter that frame.
REQ-033 bcd inputs are sampled only at grant; changes after the ack cycle have no effect on the frame in flight.

Reset
REQ-034 rst has priority over all activity, including mid-frame, and takes effect at the next edge:
- FSM goes to IDLE.
- ser_data, ser_clk, ser_latch, busy, frame_done, ack_result and ack_entry are all 0.
- Frame register, last-frame register and refresh counter are all 0.
- The "frame sent" flag is cleared, so no refresh occurs until the first granted request.
REQ-035 An external shift register left partially loaded by a mid-frame reset is not latched; ser_latch stays 0.

Verification
REQ-036 The bench SHALL cover these directed scenarios (DIV=2):
- req_result=1, bcd_result=16'h1234, err_in=0 -> ack_result pulses once; ser_data sampled on 32 ser_clk rising edges = 60DAF266 MSB first; ser_latch high 2 cycles; frame_done 132 cycles after grant.
- req_result and req_entry both high, bcd_entry=16'h0009 -> ack_result first; after its frame_done, ack_entry pulses; second frame = FCFCFCF6.
- err_in=1 with req_entry, bcd_entry=16'h5678 -> frame shifts 02020202; ack_entry pulses.
- bcd_result=16'hA0F9 -> frame 02FC02F6.
- REFRESH=10, one frame sent, no requests -> second identical frame begins exactly 10 IDLE cycles after frame_done, with no ack pulse.
- rst asserted at bit 15 of a frame -> next cycle all outputs 0 and busy=0; no ser_latch; no refresh until a new request.

Source files
------------

// File: rtl/display_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// display_sched_if
// Request/acknowledge and serial display bus for display_sched.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface display_sched_if;
  logic        req_result;
  logic [15:0] bcd_result;
  logic        req_entry;
  logic [15:0] bcd_entry;
  logic        err_in;
  logic        ack_result;
  logic        ack_entry;
  logic        ser_data;
  logic        ser_clk;
  logic        ser_latch;
  logic        busy;
  logic        frame_done;

  // Requesting side: drives requests and digits, observes the display bus.
  modport master (
    output req_result, bcd_result, req_entry, bcd_entry, err_in,
    input  ack_result, ack_entry, ser_data, ser_clk, ser_latch, busy, frame_done
  );

  // Scheduler side.
  modport slave (
    input  req_result, bcd_result, req_entry, bcd_entry, err_in,
    output ack_result, ack_entry, ser_data, ser_clk, ser_latch, busy, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/display_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// display_sched
// Arbitrates result/entry display requests and shifts a 32-bit 7-segment
// frame into an external shift register, with periodic refresh.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module display_sched #(
  parameter int DIV     = 2,
  parameter int REFRESH = 1000
) (
  input  logic          clk,
  input  logic          rst,
  display_sched_if.slave disp
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_SHIFT_LO = 3'd2;
  localparam logic [2:0] S_SHIFT_HI = 3'd3;
  localparam logic [2:0] S_LATCH    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam int           RW         = $clog2(REFRESH + 1);
  localparam logic [7:0]   c_DIV_LAST = 8'(DIV - 1);
  localparam logic [RW-1:0] c_REF_MAX  = RW'(REFRESH);
  localparam logic [RW-1:0] c_REF_LAST = RW'(REFRESH - 1);

  logic [2:0]    state_q, state_d;
  logic [31:0]   frame_q, frame_d;
  logic [31:0]   last_q, last_d;
  logic          ser_data_q, ser_data_d;
  logic [4:0]    bit_q, bit_d;
  logic [7:0]    div_q, div_d;
  logic [RW-1:0] ref_q, ref_d;
  logic          sent_q, sent_d;

  logic          grant_res, grant_ent, grant_ref;
  logic [15:0]   sel_bcd;
  logic [31:0]   new_frame;

  // abcdefg,dp segment pattern; non-decimal nibbles show a dash
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hFC;
      4'd1:    seg7 = 8'h60;
      4'd2:    seg7 = 8'hDA;
      4'd3:    seg7 = 8'hF2;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'hB6;
      4'd6:    seg7 = 8'hBE;
      4'd7:    seg7 = 8'hE0;
      4'd8:    seg7 = 8'hFE;
      4'd9:    seg7 = 8'hF6;
      default: seg7 = 8'h02;
    endcase
  endfunction

  // Fixed priority in IDLE: result, then entry, then refresh of the last frame.
  // Refresh fires on the IDLE cycle whose increment brings the counter to
  // REFRESH, so exactly REFRESH idle cycles separate frame_done from LOAD.
  assign grant_res = (state_q == S_IDLE) && disp.req_result;
  assign grant_ent = (state_q == S_IDLE) && !disp.req_result && disp.req_entry;
  assign grant_ref = (state_q == S_IDLE) && !disp.req_result && !disp.req_entry &&
                     sent_q && (ref_q >= c_REF_LAST);

  assign sel_bcd   = grant_res ? disp.bcd_result : disp.bcd_entry;
  assign new_frame = disp.err_in ? 32'h0202_0202 :
                     {seg7(sel_bcd[15:12]), seg7(sel_bcd[11:8]),
                      seg7(sel_bcd[7:4]),   seg7(sel_bcd[3:0])};

  // Next-state logic for the frame sequencer
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    last_d     = last_q;
    ser_data_d = ser_data_q;
    bit_d      = bit_q;
    div_d      = div_q;
    ref_d      = ref_q;
    sent_d     = sent_q;
    case (state_q)
      S_IDLE: begin
        if (ref_q < c_REF_MAX) ref_d = ref_q + 1'b1;
        if (grant_res || grant_ent || grant_ref) begin
          frame_d    = grant_ref ? last_q : new_frame;
          last_d     = frame_d;
          ser_data_d = frame_d[31];
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        bit_d   = 5'd0;
        div_d   = 8'd0;
        state_d = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (div_q == c_DIV_LAST) begin
          div_d   = 8'd0;
          state_d = S_SHIFT_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_SHIFT_HI: begin
        if (div_q == c_DIV_LAST) begin
          div_d = 8'd0;
          if (bit_q == 5'd31) begin
            state_d = S_LATCH;
          end else begin
            // Next bit is presented only as the clock falls
            bit_d      = bit_q + 5'd1;
            frame_d    = {frame_q[30:0], 1'b0};
            ser_data_d = frame_q[30];
            state_d    = S_SHIFT_LO;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_LATCH: begin
        if (div_q == c_DIV_LAST) begin
          div_d   = 8'd0;
          state_d = S_DONE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_DONE: begin
        ref_d   = '0;
        sent_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any frame in flight without latching it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      last_q     <= '0;
      ser_data_q <= 1'b0;
      bit_q      <= '0;
      div_q      <= '0;
      ref_q      <= '0;
      sent_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      last_q     <= last_d;
      ser_data_q <= ser_data_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      ref_q      <= ref_d;
      sent_q     <= sent_d;
    end
  end

  // Acks are the grant itself, so they coincide with the IDLE cycle that grants
  assign disp.ack_result = grant_res && !rst;
  assign disp.ack_entry  = grant_ent && !rst;
  assign disp.ser_data   = ser_data_q;
  assign disp.ser_clk    = (state_q == S_SHIFT_HI);
  assign disp.ser_latch  = (state_q == S_LATCH);
  assign disp.busy       = (state_q != S_IDLE);
  assign disp.frame_done = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_display_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_display_sched
// Scoreboard bench for display_sched: stimulus queues expected acks/frames,
// a monitor reassembles shifted frames and checks them.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_display_sched;
  localparam int DIV     = 2;
  localparam int REFRESH = 10;
  localparam int LAT     = 1 + 64 * DIV + DIV + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_sched_if bus();

  display_sched #(.DIV(DIV), .REFRESH(REFRESH)) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (bus)
  );

  typedef struct {
    logic [31:0] frame;
    int          gap;
  } exp_t;

  exp_t frame_q[$];
  int   ack_q[$];   // 0 = result, 1 = entry

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] f, input int gap);
    exp_t e;
    e.frame = f;
    e.gap   = gap;
    frame_q.push_back(e);
  endtask

  // Monitor
  logic [31:0] shreg = '0;
  int   nbits = 0, nlatch = 0, rise_cyc = 0, fd_cyc = 0, gap_obs = 0;
  logic prev_sclk = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (rst) begin
      nbits = 0; nlatch = 0; prev_sclk = 1'b0; prev_busy = 1'b0;
    end else begin
      if (bus.busy && !prev_busy) begin
        gap_obs = cyc - fd_cyc; rise_cyc = cyc; nbits = 0; nlatch = 0;
      end
      prev_busy = bus.busy;
      if (bus.ser_clk && !prev_sclk) begin
        shreg = {shreg[30:0], bus.ser_data};
        nbits++;
      end
      prev_sclk = bus.ser_clk;
      if (bus.ser_latch) nlatch++;
      if (bus.ack_result || bus.ack_entry) begin
        if (ack_q.size() == 0) begin
          check("unexpected_ack", {bus.ack_result, bus.ack_entry}, 2'b00);
        end else begin
          k = ack_q.pop_front();
          check("ack_kind", {bus.ack_result, bus.ack_entry}, (k == 0) ? 2'b10 : 2'b01);
        end
      end
      if (bus.frame_done) begin
        if (frame_q.size() == 0) begin
          check("unexpected_frame", shreg, 32'hx);
        end else begin
          e = frame_q.pop_front();
          check("frame_bits", shreg, e.frame);
          check("bit_count", nbits, 32);
          check("latch_cycles", nlatch, DIV);
          check("latency", cyc - (rise_cyc - 1), LAT);
          if (e.gap >= 0) check("idle_gap", gap_obs, e.gap);
        end
        fd_cyc = cyc;
      end
    end
  end

  // Stimulus helpers
  task automatic drv_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_sig(input int which, input string name);
    int   t;
    logic s;
    t = 0;
    forever begin
      @(negedge clk);
      case (which)
        0:       s = bus.ack_result | bus.ack_entry;
        1:       s = bus.frame_done;
        default: s = bus.busy;
      endcase
      if (s) return;
      t++;
      if (t > 2000) begin
        compared++;
        mismatched++;
        $display("FAIL timeout_%s: event not seen, expected within 2000 cycles", name);
        return;
      end
    end
  endtask

  initial begin
    int seen;
    bus.req_result = 1'b0; bus.bcd_result = '0;
    bus.req_entry  = 1'b0; bus.bcd_entry  = '0;
    bus.err_in     = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  bus.busy, 1'b0);
    check("rst_outs",  {bus.ser_data, bus.ser_clk, bus.ser_latch, bus.frame_done,
                        bus.ack_result, bus.ack_entry}, 6'b0);
    drv_slot();
    rst = 1'b0;

    // No refresh before any frame has been sent
    seen = 0;
    repeat (30) begin @(negedge clk); if (bus.busy) seen++; end
    check("no_refresh_initially", seen, 0);

    // T1: basic result frame; bcd changes after ack must not matter
    drv_slot();
    bus.bcd_result = 16'h1234; bus.req_result = 1'b1;
    ack_q.push_back(0); push_frame(32'h60DAF266, -1);
    wait_sig(0, "ack_t1");
    drv_slot();
    bus.req_result = 1'b0; bus.bcd_result = 16'hFFFF;
    wait_sig(1, "fd_t1");

    // T2: simultaneous requests, result wins, entry follows right after
    drv_slot();
    bus.bcd_result = 16'h0770; bus.bcd_entry = 16'h0009;
    bus.req_result = 1'b1; bus.req_entry = 1'b1;
    ack_q.push_back(0); push_frame(32'hFCE0E0FC, -1);
    ack_q.push_back(1); push_frame(32'hFCFCFCF6, 2);
    wait_sig(0, "ack_t2a");
    drv_slot();
    bus.req_result = 1'b0;
    wait_sig(1, "fd_t2a");
    wait_sig(0, "ack_t2b");
    drv_slot();
    bus.req_entry = 1'b0;
    wait_sig(1, "fd_t2b");

    // T3: error forces dashes; dropping err_in mid-frame has no effect
    drv_slot();
    bus.err_in = 1'b1; bus.bcd_entry = 16'h5678; bus.req_entry = 1'b1;
    ack_q.push_back(1); push_frame(32'h02020202, -1);
    wait_sig(0, "ack_t3");
    drv_slot();
    bus.req_entry = 1'b0; bus.err_in = 1'b0;
    wait_sig(1, "fd_t3");

    // T4: non-decimal digits; raising err_in mid-frame has no effect
    drv_slot();
    bus.bcd_result = 16'hA0F9; bus.req_result = 1'b1;
    ack_q.push_back(0); push_frame(32'h02FC02F6, -1);
    wait_sig(0, "ack_t4");
    drv_slot();
    bus.req_result = 1'b0; bus.err_in = 1'b1; bus.bcd_result = 16'h1111;
    wait_sig(1, "fd_t4");
    bus.err_in = 1'b0;

    // T5: refresh resends last frame after REFRESH idle cycles, no ack
    push_frame(32'h02FC02F6, REFRESH + 1);
    wait_sig(2, "busy_t5");
    wait_sig(1, "fd_t5");

    // T6: reset in the middle of a frame
    drv_slot();
    bus.bcd_result = 16'h9876; bus.req_result = 1'b1;
    ack_q.push_back(0);
    wait_sig(0, "ack_t6");
    drv_slot();
    bus.req_result = 1'b0;
    begin
      int t;
      t = 0;
      while (nbits < 15 && t < 2000) begin @(negedge clk); t++; end
      check("reached_bit15", (nbits >= 15), 1'b1);
    end
    drv_slot();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_outs", {bus.ser_data, bus.ser_clk, bus.ser_latch, bus.frame_done,
                          bus.ack_result, bus.ack_entry}, 6'b0);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.busy || bus.ser_latch || bus.frame_done) seen++;
    end
    check("quiet_after_midrst", seen, 0);

    check("frames_pending", frame_q.size(), 0);
    check("acks_pending", ack_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
